// File: rtl/wr_mon_pkg.sv
// wr_mon_pkg: shared write-monitor defaults, count width helper and the per-slot tracking record
package wr_mon_pkg;
  localparam int unsigned NumSlotsDef = 2;
  localparam int unsigned IdWidthDef = 4;
  localparam int unsigned CntWidthDef = 10;
  localparam int unsigned MaxTxnPerIdDef = 4;
  function automatic int unsigned txn_width(input int unsigned max_txn);
    return $clog2(max_txn + 1);
  endfunction
  localparam int unsigned TxnWidthDef = txn_width(MaxTxnPerIdDef);
  typedef struct packed {
    logic [IdWidthDef-1:0]  id;
    logic [TxnWidthDef-1:0] num_txn;
    logic [CntWidthDef-1:0] txn_budget;
    logic                   free;
  } id_track_t;
endpackage

// File: rtl/wr_free_sel.sv
// wr_free_sel: lowest-index free slot picker; free_i in, one-hot gnt_o and valid_o out
module wr_free_sel #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] free_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);
  assign gnt_o = free_i & (~free_i + N'(1));
  assign valid_o = |free_i;
endmodule

// File: rtl/wr_slot_alloc.sv
// wr_slot_alloc: write ID slot allocator; watches AW/B handshakes, drives next slot state id_track_d_o from id_track_q_i, gates AW via aw_stall_o, sticky timeout_o/timeout_idx_o/unexp_b_o cleared by clear_i
module wr_slot_alloc
  import wr_mon_pkg::*;
#(
  parameter int unsigned NumSlots = NumSlotsDef,
  parameter int unsigned IdWidth = IdWidthDef,
  parameter int unsigned MaxTxnPerId = MaxTxnPerIdDef,
  parameter int unsigned CntWidth = CntWidthDef,
  parameter type id_track_t = wr_mon_pkg::id_track_t
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [CntWidth-1:0]           budget_i,
  input  logic                          aw_valid_i,
  input  logic                          aw_ready_i,
  input  logic [IdWidth-1:0]            aw_id_i,
  input  logic                          b_valid_i,
  input  logic                          b_ready_i,
  input  logic [IdWidth-1:0]            b_id_i,
  input  id_track_t [NumSlots-1:0]      id_track_q_i,
  output id_track_t [NumSlots-1:0]      id_track_d_o,
  output logic                          aw_stall_o,
  input  logic                          clear_i,
  output logic                          timeout_o,
  output logic [NumSlots-1:0]           timeout_idx_o,
  output logic                          unexp_b_o
);
  localparam int unsigned TxnWidth = txn_width(MaxTxnPerId);
  localparam logic [TxnWidth-1:0] TxnMax = TxnWidth'(MaxTxnPerId);
  localparam logic [TxnWidth-1:0] TxnOne = TxnWidth'(1);
  logic aw_hs, b_hs, aw_hit_any, b_hit_any, free_any, aw_full, aw_do, aw_new, unexp_q;
  logic [NumSlots-1:0] aw_hit, b_hit, free_vec, full_vec, gnt, to_set, timeout_idx_q;
  for (genvar i = 0; i < NumSlots; i++) begin : g_slot
    assign free_vec[i] = id_track_q_i[i].free;
    assign aw_hit[i] = ~id_track_q_i[i].free & (id_track_q_i[i].id == aw_id_i);
    assign b_hit[i] = ~id_track_q_i[i].free & (id_track_q_i[i].id == b_id_i);
    assign full_vec[i] = id_track_q_i[i].num_txn == TxnMax;
    assign to_set[i] = ~id_track_q_i[i].free & (id_track_q_i[i].txn_budget == '0);
  end
  wr_free_sel #(.N(NumSlots)) u_free_sel (
    .free_i  (free_vec),
    .gnt_o   (gnt),
    .valid_o (free_any)
  );
  assign aw_hs = aw_valid_i & aw_ready_i;
  assign b_hs = b_valid_i & b_ready_i;
  assign aw_hit_any = |aw_hit;
  assign b_hit_any = |b_hit;
  assign aw_full = |(aw_hit & full_vec);
  assign aw_stall_o = aw_valid_i & ((~aw_hit_any & ~free_any) | aw_full);
  assign aw_do = aw_hs & ~aw_stall_o;
  assign aw_new = aw_do & ~aw_hit_any;
  always_comb begin
    id_track_d_o = id_track_q_i;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      if (rst_ni) begin
        if (aw_new && gnt[i]) begin
          id_track_d_o[i].free = 1'b0;
          id_track_d_o[i].id = aw_id_i;
          id_track_d_o[i].num_txn = TxnOne;
          id_track_d_o[i].txn_budget = budget_i;
        end else if (aw_do && aw_hit[i] && b_hs && b_hit[i]) begin
          id_track_d_o[i].txn_budget = budget_i;
        end else if (aw_do && aw_hit[i]) begin
          id_track_d_o[i].num_txn = id_track_q_i[i].num_txn + TxnOne;
        end else if (b_hs && b_hit[i]) begin
          id_track_d_o[i].num_txn = id_track_q_i[i].num_txn - TxnOne;
          id_track_d_o[i].free = id_track_q_i[i].num_txn == TxnOne;
          id_track_d_o[i].txn_budget = budget_i;
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unexp_q <= 1'b0;
      timeout_idx_q <= '0;
    end else begin
      unexp_q <= (b_hs & ~b_hit_any) | (unexp_q & ~clear_i);
      timeout_idx_q <= to_set | (timeout_idx_q & {NumSlots{~clear_i}});
    end
  end
  assign unexp_b_o = unexp_q;
  assign timeout_idx_o = timeout_idx_q;
  assign timeout_o = |timeout_idx_q;
endmodule

// File: tb/tb_wr_slot_alloc.sv
// tb_wr_slot_alloc: directed scoreboard bench for wr_slot_alloc with a registered stand-in for the slot counters
module tb_wr_slot_alloc;
  import wr_mon_pkg::*;
  typedef struct {
    string     name;
    int        cyc;
    logic      stall;
    logic      unexp;
    logic      to;
    logic [1:0] idx;
    id_track_t s0;
    id_track_t s1;
  } exp_t;
  logic clk, rst_n, aw_valid, aw_ready, b_valid, b_ready, clear, aw_stall, timeout, unexp_b;
  logic [3:0] aw_id, b_id;
  logic [9:0] budget;
  logic [1:0] timeout_idx;
  id_track_t [1:0] q, d;
  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  wr_slot_alloc dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .budget_i      (budget),
    .aw_valid_i    (aw_valid),
    .aw_ready_i    (aw_ready),
    .aw_id_i       (aw_id),
    .b_valid_i     (b_valid),
    .b_ready_i     (b_ready),
    .b_id_i        (b_id),
    .id_track_q_i  (q),
    .id_track_d_o  (d),
    .aw_stall_o    (aw_stall),
    .clear_i       (clear),
    .timeout_o     (timeout),
    .timeout_idx_o (timeout_idx),
    .unexp_b_o     (unexp_b)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int i = 0; i < 2; i++) q[i] <= '{id: '0, num_txn: '0, txn_budget: budget, free: 1'b1};
    else
      q <= d;
  end
  function automatic id_track_t slot(input logic [3:0] id, input logic [2:0] n, input logic [9:0] b, input logic f);
    return '{id: id, num_txn: n, txn_budget: b, free: f};
  endfunction
  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc != cyc) cmp(e.name, "cycle", cyc, e.cyc);
      cmp(e.name, "aw_stall", {31'b0, aw_stall}, {31'b0, e.stall});
      cmp(e.name, "unexp_b", {31'b0, unexp_b}, {31'b0, e.unexp});
      cmp(e.name, "timeout", {29'b0, timeout, timeout_idx}, {29'b0, e.to, e.idx});
      cmp(e.name, "slot0", 32'(q[0]), 32'(e.s0));
      cmp(e.name, "slot1", 32'(q[1]), 32'(e.s1));
    end
  end
  task automatic drive(input string nm, input logic awv, input logic [3:0] awid, input logic bv, input logic [3:0] bid,
                       input logic [9:0] bud, input logic clr, input logic rn, input logic es, input logic eu,
                       input logic et, input logic [1:0] ei, input id_track_t e0, input id_track_t e1);
    @(posedge clk);
    #1;
    aw_valid = awv;
    aw_id = awid;
    b_valid = bv;
    b_id = bid;
    budget = bud;
    clear = clr;
    rst_n = rn;
    sb.push_back('{name: nm, cyc: cyc, stall: es, unexp: eu, to: et, idx: ei, s0: e0, s1: e1});
  endtask
  initial begin
    id_track_t fr, s0, s1;
    fr = slot(0, 0, 100, 1);
    rst_n = 0;
    aw_valid = 0;
    aw_ready = 1;
    aw_id = 0;
    b_valid = 0;
    b_ready = 1;
    b_id = 0;
    budget = 100;
    clear = 0;
    repeat (3) @(posedge clk);
    drive("reset_state", 0, 0, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, fr, fr);
    drive("aw3_alloc",   1, 3, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, fr, fr);
    drive("aw3_n1",      1, 3, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, slot(3, 1, 100, 0), fr);
    drive("aw3_n2",      1, 3, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, slot(3, 2, 100, 0), fr);
    drive("aw3_n3",      1, 3, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, slot(3, 3, 100, 0), fr);
    drive("aw3_full",    1, 3, 0, 0, 55,  0, 1, 1, 0, 0, 2'b00, slot(3, 4, 100, 0), fr);
    drive("b3_a",        0, 0, 1, 3, 90,  0, 1, 0, 0, 0, 2'b00, slot(3, 4, 100, 0), fr);
    drive("b3_b",        0, 0, 1, 3, 90,  0, 1, 0, 0, 0, 2'b00, slot(3, 3, 90, 0), fr);
    drive("aw5_alloc",   1, 5, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, slot(3, 2, 90, 0), fr);
    drive("aw7_nofree",  1, 7, 0, 0, 100, 0, 1, 1, 0, 0, 2'b00, slot(3, 2, 90, 0), slot(5, 1, 100, 0));
    drive("aw7_b5_same", 1, 7, 1, 5, 100, 0, 1, 1, 0, 0, 2'b00, slot(3, 2, 90, 0), slot(5, 1, 100, 0));
    drive("aw7_alloc1",  1, 7, 0, 0, 60,  0, 1, 0, 0, 0, 2'b00, slot(3, 2, 90, 0), slot(5, 0, 100, 1));
    drive("aw3_b3_sim",  1, 3, 1, 3, 77,  0, 1, 0, 0, 0, 2'b00, slot(3, 2, 90, 0), slot(7, 1, 60, 0));
    s0 = slot(3, 2, 77, 0);
    s1 = slot(7, 1, 60, 0);
    drive("sim_result",  0, 0, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, s0, s1);
    drive("b9_unexp",    0, 0, 1, 9, 100, 0, 1, 0, 0, 0, 2'b00, s0, s1);
    drive("unexp_set",   0, 0, 0, 0, 100, 0, 1, 0, 1, 0, 2'b00, s0, s1);
    drive("unexp_hold",  0, 0, 0, 0, 100, 0, 1, 0, 1, 0, 2'b00, s0, s1);
    drive("clear",       0, 0, 0, 0, 100, 1, 1, 0, 1, 0, 2'b00, s0, s1);
    drive("b9_clear",    0, 0, 1, 9, 100, 1, 1, 0, 0, 0, 2'b00, s0, s1);
    drive("set_wins",    0, 0, 0, 0, 100, 1, 1, 0, 1, 0, 2'b00, s0, s1);
    drive("aw7_b7_bud0", 1, 7, 1, 7, 0,   0, 1, 0, 0, 0, 2'b00, s0, s1);
    drive("bud_zero",    0, 0, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, s0, slot(7, 1, 0, 0));
    drive("timeout_set", 0, 0, 0, 0, 100, 0, 1, 0, 0, 1, 2'b10, s0, slot(7, 1, 0, 0));
    drive("timeout_hold",0, 0, 0, 0, 100, 0, 1, 0, 0, 1, 2'b10, s0, slot(7, 1, 0, 0));
    drive("reset_mid",   0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 2'b00, fr, fr);
    drive("reset_rel",   0, 0, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, fr, fr);
    drive("post_reset",  0, 0, 0, 0, 100, 0, 1, 0, 0, 0, 2'b00, fr, fr);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wr_slot_alloc.md
WR_SLOT_ALLOC -- requirements
Module: wr_slot_alloc

Interface
REQ-001 SHALL have parameter NumSlots, default 2, meaning the number of write ID tracking slots.
REQ-002 SHALL have parameter IdWidth, default 4, meaning the AXI ID width.
REQ-003 SHALL have parameter MaxTxnPerId, default 4, meaning the maximum outstanding writes per slot.
REQ-004 SHALL have parameter CntWidth, default 10, meaning the budget counter width.
REQ-005 SHALL have parameter id_track_t, default the shared package type, meaning the slot record {id, num_txn, txn_budget, free}.
REQ-006 SHALL have port clk_i, input, 1, clock.
REQ-007 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port budget_i, input, CntWidth, meaning the cycle budget loaded on allocate or reload.
REQ-009 SHALL have ports aw_valid_i, aw_ready_i (input, 1) and aw_id_i (input, IdWidth), the observed AW channel.
REQ-010 SHALL have ports b_valid_i, b_ready_i (input, 1) and b_id_i (input, IdWidth), the observed B channel.
REQ-011 SHALL have port id_track_q_i, input, NumSlots x id_track_t, the current slot state returned by the per-slot counters.
REQ-012 SHALL have port id_track_d_o, output, NumSlots x id_track_t, the next slot state driven to the per-slot counters.
REQ-013 SHALL have port aw_stall_o, output, 1, requesting that the AW handshake be gated.
REQ-014 SHALL have port clear_i, input, 1, clearing the sticky flags.
REQ-015 SHALL have ports timeout_o (output, 1) and timeout_idx_o (output, NumSlots one-hot), giving the sticky timeout flag and the slot that timed out.
REQ-016 SHALL have port unexp_b_o, output, 1, a sticky flag for a B response with no matching slot.

Function
REQ-017 SHALL define "hit" as a slot with free==0 and id equal to the channel ID; at most one slot hits any ID.
REQ-018 SHALL default id_track_d_o[i] to id_track_q_i[i] when no event targets slot i.
REQ-019 On an AW handshake that hits slot i: num_txn+1 and txn_budget unchanged.
REQ-020 On an AW handshake with no hit: allocate the lowest-index free slot, setting free=0, id=aw_id_i, num_txn=1 and txn_budget=budget_i.
REQ-021 On a B handshake that hits slot i with num_txn>1: num_txn-1 and txn_budget=budget_i.
REQ-022 On a B handshake that hits slot i with num_txn==1: free=1, num_txn=0 and txn_budget=budget_i.
REQ-023 On simultaneous AW and B handshakes hitting the same slot: num_txn unchanged and txn_budget=budget_i.
REQ-024 A slot freed in cycle t SHALL NOT be allocatable before cycle t+1; allocation uses q state only.
REQ-025 aw_stall_o SHALL be combinational and high when aw_valid_i is high and either (no hit and no free slot) or (the hit slot has num_txn==MaxTxnPerId).
REQ-026 An AW handshake while aw_stall_o is high SHALL be ignored (slot state unchanged).
REQ-027 A B handshake with no hit SHALL set unexp_b_o the next cycle and SHALL leave slot state unchanged.
REQ-028 Any slot with free==0 and txn_budget==0 SHALL set timeout_o the next cycle and OR its bit into timeout_idx_o.
REQ-029 The sticky flags SHALL stay set until clear_i; if clear_i coincides with a new set event, the set SHALL win.
REQ-030 num_txn SHALL be $clog2(MaxTxnPerId+1) bits wide and SHALL never wrap.

Reset
REQ-031 On reset, timeout_o, timeout_idx_o and unexp_b_o SHALL be 0.
REQ-032 During reset, id_track_d_o SHALL pass id_track_q_i, and the counters SHALL own slot reset (free=1, txn_budget=budget).

Structure
REQ-033 id_track_t, the NumSlots/IdWidth/CntWidth defaults and the count width helper SHALL live in the shared package wr_mon_pkg.
REQ-034 First-free-slot selection SHALL be one sub-module, wr_free_sel (priority encoder producing one-hot grant and valid).
REQ-035 Per-slot counting/decrement SHALL remain in the downstream counter instances; this block SHALL NOT decrement budgets.

Verification
REQ-036 The bench SHALL cover: all slots free, AW id=3 with budget_i=100 -> slot0 free=0, id=3, num_txn=1, txn_budget=100.
REQ-037 The bench SHALL cover: AW id=3 three more times -> slot0 num_txn=4; fifth AW id=3 -> aw_stall_o=1 and state unchanged.
REQ-038 The bench SHALL cover: slots 0/1 holding ids 3/5, AW id=7 -> aw_stall_o=1; B id=5 (num_txn=1) -> slot1 free the next cycle, then AW id=7 -> slot1 allocated.
REQ-039 The bench SHALL cover: simultaneous AW and B id=3, num_txn=2 -> num_txn=2 and txn_budget=budget_i.
REQ-040 The bench SHALL cover: B id=9 with no slot -> unexp_b_o=1 the next cycle and held until clear_i.
REQ-041 The bench SHALL cover: slot1 busy with txn_budget reaching 0 -> timeout_o=1 and timeout_idx_o=2'b10; reset mid-operation -> all flags 0.
